// File: rtl/pdm_ahb_pkg.sv
// pdm_ahb_pkg: register map, bit positions and sequencer states for the PDM capture slave
package pdm_ahb_pkg;
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_DATA   = 8'h08;
  localparam logic [7:0] OFF_THRESH = 8'h0C;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_IEN      = 1;
  localparam int CTRL_FLUSH    = 2;
  localparam int CTRL_MASK_LSB = 8;
  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_OVF   = 18;
  localparam int ST_UNF   = 19;
  typedef enum logic {SEQ_IDLE, SEQ_PUSH} seq_state_e;
  function automatic logic [31:0] fifo_word(input logic [3:0] ch, input logic [15:0] cnt);
    return {ch, 12'h000, cnt};
  endfunction
endpackage

// File: rtl/pdm_sync_fifo.sv
// pdm_sync_fifo: single-clock FIFO with push, pop, one-cycle flush and occupancy level
module pdm_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 32
) (
  input  logic                       g_hclk_es1,
  input  logic                       hreset_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  assign full_o  = level_q == LW'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  assign rdata_o = mem[rptr_q];
  assign do_pop  = pop_i & ~empty_o;
  // a pop on a full FIFO frees the slot for a push in the same cycle
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge g_hclk_es1 or negedge hreset_n)
    if (!hreset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= inc(wptr_q);
      if (do_pop) rptr_q <= inc(rptr_q);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  always_ff @(posedge g_hclk_es1)
    if (do_push && !flush_i) mem[wptr_q] <= wdata_i;
endmodule

// File: rtl/ahb_pdm_mc_capture.sv
// ahb_pdm_mc_capture: AHB-Lite slave decimating NCH PDM streams into a shared, channel-tagged FIFO
module ahb_pdm_mc_capture
  import pdm_ahb_pkg::*;
#(
  parameter int          NCH        = 2,
  parameter int          DECIM      = 64,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h8018_0000
) (
  input  logic           g_hclk_es1,
  input  logic           hreset_n,
  input  logic           hsel_es1,
  input  logic [31:0]    haddr,
  input  logic [1:0]     htrans,
  input  logic           hwrite,
  input  logic [2:0]     hsize,
  input  logic           hready,
  input  logic [31:0]    hwdata,
  output logic [31:0]    hrdata_es1,
  output logic           hreadyout_es1,
  output logic           hresp_es1,
  input  logic           pdm_clk,
  input  logic [NCH-1:0] pdm_data,
  output logic           irq
);
  localparam int CW = $clog2(DECIM+1);
  localparam int BW = $clog2(DECIM);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  logic ap_q, wr_q, wait_q;
  logic [7:0] off_q;
  logic en_q, ien_q, ovf_q, unf_q, irq_q;
  logic [NCH-1:0] mask_q;
  logic [15:0] thresh_q;
  logic acc, rd_ph, wr_ph, data_rd, pop_req, w_ctrl, w_stat, w_thr, flush;
  logic [2:0] pclk_q;
  logic [NCH-1:0] pd0_q, pd1_q;
  logic tick, frame_end;
  logic [BW-1:0] bcnt_q;
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] hold_q [NCH];
  logic [CW-1:0] nxt_cnt [NCH];
  seq_state_e state_q, state_d;
  logic [3:0] ch_q, ch_d;
  logic push, cur_en;
  logic [CW-1:0] cur_cnt;
  logic [31:0] fifo_rdata;
  logic [LW-1:0] level;
  logic empty, full;
  logic unused;
  assign unused    = ^{hsize, htrans[0], hwdata};
  assign hresp_es1 = 1'b0;
  assign irq       = irq_q;
  assign acc     = hsel_es1 & htrans[1] & hready & (haddr[31:8] == BASE_ADDR[31:8]);
  assign rd_ph   = ap_q & ~wr_q;
  assign wr_ph   = ap_q & wr_q;
  assign data_rd = rd_ph & (off_q == OFF_DATA);
  // DATA reads stall one cycle so the FIFO head is presented and popped on the completing cycle
  assign hreadyout_es1 = ~(data_rd & ~wait_q);
  assign pop_req = data_rd & wait_q;
  assign w_ctrl  = wr_ph & (off_q == OFF_CTRL);
  assign w_stat  = wr_ph & (off_q == OFF_STATUS);
  assign w_thr   = wr_ph & (off_q == OFF_THRESH);
  assign flush   = w_ctrl & hwdata[CTRL_FLUSH];
  always_ff @(posedge g_hclk_es1 or negedge hreset_n)
    if (!hreset_n) begin
      ap_q     <= 1'b0;
      wr_q     <= 1'b0;
      off_q    <= '0;
      wait_q   <= 1'b0;
      en_q     <= 1'b0;
      ien_q    <= 1'b0;
      mask_q   <= '0;
      thresh_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (hready) begin
        ap_q  <= acc;
        wr_q  <= hwrite;
        off_q <= haddr[7:0];
      end
      wait_q <= data_rd & ~wait_q;
      if (w_ctrl) begin
        en_q   <= hwdata[CTRL_EN];
        ien_q  <= hwdata[CTRL_IEN];
        mask_q <= hwdata[CTRL_MASK_LSB +: NCH];
      end
      if (w_thr) thresh_q <= hwdata[15:0];
      ovf_q <= (ovf_q & ~(w_stat & hwdata[ST_OVF])) | (push & full & ~(pop_req & ~empty));
      unf_q <= (unf_q & ~(w_stat & hwdata[ST_UNF])) | (pop_req & empty);
      irq_q <= ien_q & (((16'(level) >= thresh_q) & (thresh_q != '0)) | ovf_q);
    end
  always_comb begin
    hrdata_es1 = !rd_ph ? '0 :
                 off_q == OFF_CTRL   ? {16'h0, 8'(mask_q), 5'h0, 1'b0, ien_q, en_q} :
                 off_q == OFF_STATUS ? {12'h0, unf_q, ovf_q, full, empty, 16'(level)} :
                 off_q == OFF_DATA   ? ((wait_q & ~empty) ? fifo_rdata : '0) :
                 off_q == OFF_THRESH ? {16'h0, thresh_q} : '0;
  end
  always_ff @(posedge g_hclk_es1 or negedge hreset_n)
    if (!hreset_n) begin
      pclk_q <= '0;
      pd0_q  <= '0;
      pd1_q  <= '0;
    end else begin
      pclk_q <= {pclk_q[1:0], pdm_clk};
      pd0_q  <= pdm_data;
      pd1_q  <= pd0_q;
    end
  assign tick      = pclk_q[1] & ~pclk_q[2];
  assign frame_end = en_q & tick & (bcnt_q == BW'(DECIM-1));
  always_comb begin
    for (int c = 0; c < NCH; c++) nxt_cnt[c] = cnt_q[c] + CW'(mask_q[c] & pd1_q[c]);
  end
  always_ff @(posedge g_hclk_es1 or negedge hreset_n)
    if (!hreset_n) begin
      bcnt_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]  <= '0;
        hold_q[c] <= '0;
      end
    end else if (!en_q) begin
      bcnt_q <= '0;
      for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
    end else if (tick) begin
      bcnt_q <= frame_end ? '0 : bcnt_q + 1'b1;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= frame_end ? '0 : nxt_cnt[c];
        if (frame_end) hold_q[c] <= nxt_cnt[c];
      end
    end
  always_comb begin
    cur_cnt = '0;
    cur_en  = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (ch_q == 4'(c)) begin
        cur_cnt = hold_q[c];
        cur_en  = mask_q[c];
      end
  end
  always_ff @(posedge g_hclk_es1 or negedge hreset_n)
    if (!hreset_n) begin
      state_q <= SEQ_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  // a new frame end always restarts the walk at channel 0
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    push    = 1'b0;
    if (!en_q) begin
      state_d = SEQ_IDLE;
      ch_d    = '0;
    end else if (frame_end) begin
      state_d = SEQ_PUSH;
      ch_d    = '0;
    end else if (state_q == SEQ_PUSH) begin
      push    = cur_en;
      ch_d    = ch_q == 4'(NCH-1) ? '0 : ch_q + 1'b1;
      state_d = ch_q == 4'(NCH-1) ? SEQ_IDLE : SEQ_PUSH;
    end
  end
  pdm_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .g_hclk_es1(g_hclk_es1),
    .hreset_n  (hreset_n),
    .push_i    (push),
    .pop_i     (pop_req),
    .flush_i   (flush),
    .wdata_i   (fifo_word(ch_q, 16'(cur_cnt))),
    .rdata_o   (fifo_rdata),
    .level_o   (level),
    .empty_o   (empty),
    .full_o    (full)
  );
endmodule

// File: tb/tb_ahb_pdm_mc_capture.sv
// tb_ahb_pdm_mc_capture: directed AHB/PDM stimulus with a queue-based scoreboard and a decoupled monitor
module tb_ahb_pdm_mc_capture;
  localparam logic [31:0] BASE = 32'h8018_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0] htrans = '0;
  logic hwrite = 1'b0;
  logic [2:0] hsize = 3'd2;
  logic [31:0] hwdata = '0;
  logic [31:0] hrdata;
  logic hreadyout, hresp, irq, hready;
  logic pdm_clk = 1'b0;
  logic [1:0] pdm_data = '0;
  logic rd_dphase = 1'b0;
  always #5 clk = ~clk;
  assign hready = hreadyout;
  ahb_pdm_mc_capture #(.NCH(2), .DECIM(64), .FIFO_DEPTH(16), .BASE_ADDR(BASE)) dut (
    .g_hclk_es1   (clk),
    .hreset_n     (rst_n),
    .hsel_es1     (hsel),
    .haddr        (haddr),
    .htrans       (htrans),
    .hwrite       (hwrite),
    .hsize        (hsize),
    .hready       (hready),
    .hwdata       (hwdata),
    .hrdata_es1   (hrdata),
    .hreadyout_es1(hreadyout),
    .hresp_es1    (hresp),
    .pdm_clk      (pdm_clk),
    .pdm_data     (pdm_data),
    .irq          (irq)
  );
  typedef struct {string name; logic [31:0] want;} rexp_t;
  typedef struct {string name; logic [31:0] act; logic [31:0] want;} dchk_t;
  rexp_t rq[$];
  dchk_t dq[$];
  rexp_t re;
  dchk_t de;
  int checks = 0;
  int failures = 0;
  // monitor: completes a read whenever the DUT ends a read data phase, then drains sampled checks
  always @(negedge clk) begin
    if (rd_dphase && hreadyout) begin
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: got %h want no read", hrdata);
      end else begin
        re = rq.pop_front();
        if (hrdata !== re.want) begin
          failures++;
          $display("FAIL %s: got %h want %h", re.name, hrdata, re.want);
        end
      end
    end
    while (dq.size() > 0) begin
      de = dq.pop_front();
      checks++;
      if (de.act !== de.want) begin
        failures++;
        $display("FAIL %s: got %h want %h", de.name, de.act, de.want);
      end
    end
  end
  task automatic dchk(input string n, input logic [31:0] a, input logic [31:0] w);
    dchk_t d;
    d.name = n;
    d.act = a;
    d.want = w;
    dq.push_back(d);
  endtask
  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = BASE | {24'h0, off};
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    @(posedge clk); #1;
  endtask
  task automatic rd(input string n, input logic [7:0] off, input logic [31:0] w);
    rexp_t e;
    int waits = 0;
    e.name = n;
    e.want = w;
    rq.push_back(e);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = BASE | {24'h0, off};
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; rd_dphase = 1'b1;
    @(negedge clk);
    while (!hreadyout && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rd_dphase = 1'b0;
    dchk({n, "_waits"}, 32'(waits), (off == 8'h08) ? 32'd1 : 32'd0);
  endtask
  // ch0 is 1 from bit f onwards; ch1 is 1 on every k-th bit
  task automatic pdm_bits(input int n, input int f, input int k);
    for (int i = 0; i < n; i++) begin
      pdm_clk = 1'b0;
      pdm_data[0] = (i >= f);
      pdm_data[1] = (i % k == 0);
      #40;
      pdm_clk = 1'b1;
      #40;
    end
    repeat (10) @(posedge clk);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    dchk("rst_hreadyout", 32'(hreadyout), 32'd1);
    dchk("rst_irq", 32'(irq), 32'd0);
    dchk("rst_hrdata", hrdata, 32'd0);
    dchk("rst_hresp", 32'(hresp), 32'd0);
    rd("rst_status", 8'h04, 32'h0001_0000);
    rd("rst_ctrl", 8'h00, 32'h0);
    wr(8'h10, 32'hFFFF_FFFF);
    rd("unmapped", 8'h10, 32'h0);
    wr(8'h00, 32'h0000_0301);
    rd("ctrl", 8'h00, 32'h0000_0301);
    pdm_bits(64, 0, 2);
    rd("lvl2", 8'h04, 32'h0000_0002);
    rd("data_ch0", 8'h08, 32'h0000_0040);
    rd("lvl1", 8'h04, 32'h0000_0001);
    rd("data_ch1", 8'h08, 32'h1000_0020);
    rd("drained", 8'h04, 32'h0001_0000);
    wr(8'h00, 32'h0000_0201);
    pdm_bits(64, 0, 4);
    rd("mask_lvl", 8'h04, 32'h0000_0001);
    rd("mask_data", 8'h08, 32'h1000_0010);
    rd("unf_data", 8'h08, 32'h0);
    rd("unf_status", 8'h04, 32'h0009_0000);
    wr(8'h04, 32'h0008_0000);
    rd("unf_clr", 8'h04, 32'h0001_0000);
    wr(8'h00, 32'h0000_0301);
    for (int f = 0; f < 9; f++) pdm_bits(64, f, 2);
    rd("full_status", 8'h04, 32'h0006_0010);
    for (int f = 0; f < 8; f++) begin
      rd("ovf_ch0", 8'h08, 32'h40 - 32'(f));
      rd("ovf_ch1", 8'h08, 32'h1000_0020);
    end
    rd("ovf_sticky", 8'h04, 32'h0005_0000);
    wr(8'h04, 32'h0004_0000);
    rd("ovf_clr", 8'h04, 32'h0001_0000);
    wr(8'h0C, 32'h0000_0004);
    rd("thresh", 8'h0C, 32'h0000_0004);
    wr(8'h00, 32'h0000_0303);
    pdm_bits(64, 0, 2);
    dchk("irq_lvl2", 32'(irq), 32'd0);
    pdm_bits(64, 0, 2);
    dchk("irq_lvl4", 32'(irq), 32'd1);
    wr(8'h00, 32'h0000_0307);
    dchk("irq_flush_late", 32'(irq), 32'd1);
    @(posedge clk); #1;
    dchk("irq_after_flush", 32'(irq), 32'd0);
    rd("flush_status", 8'h04, 32'h0001_0000);
    rd("flush_selfclr", 8'h00, 32'h0000_0303);
    wr(8'h00, 32'h0000_0301);
    pdm_bits(30, 0, 2);
    wr(8'h00, 32'h0000_0300);
    rd("en_off_status", 8'h04, 32'h0001_0000);
    wr(8'h00, 32'h0000_0301);
    pdm_bits(64, 0, 2);
    rd("reen_lvl", 8'h04, 32'h0000_0002);
    rd("reen_ch0", 8'h08, 32'h0000_0040);
    rd("reen_ch1", 8'h08, 32'h1000_0020);
    repeat (2) @(posedge clk);
    dchk("sb_drain", 32'(rq.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
